// File: rtl/mach_pkg.sv
// Shared machine-level types: RAM arbiter state encoding and the RAM request
// bundle that the arbiter latches and that the DMA engine will reuse.
package mach_pkg;

   localparam int RAM_AW = 21;
   localparam int RAM_DW = 32;

   typedef enum logic [1:0] {
      IDLE,
      GNT_CPU,
      GNT_DMA,
      ACK
   } arb_state_t;

   // One RAM access as presented on the RAM port (strobes active-low).
   typedef struct packed {
      logic [RAM_AW-1:0] a;
      logic [RAM_DW-1:0] di;
      logic              wen;
      logic [3:0]        ben;
   } ram_req_t;

endpackage

// File: rtl/ram_arb.sv
// Round-robin arbiter sharing the main RAM port between the CPU and the DMA
// requester. The winning request is latched and held on the RAM port until
// RAM_READYn, then a one-cycle ready pulse (plus read data) returns to it.
module ram_arb
   import mach_pkg::*;
#(
   parameter int AW = RAM_AW,
   parameter int DW = RAM_DW
) (
   input  logic          CLK,
   input  logic          RES,
   input  logic          CE,

   input  logic          CPU_CEn,
   input  logic [AW-1:0] CPU_A,
   input  logic [DW-1:0] CPU_DI,
   input  logic          CPU_WEn,
   input  logic [3:0]    CPU_BEn,
   output logic [DW-1:0] CPU_DO,
   output logic          CPU_READYn,

   input  logic          DMA_CEn,
   input  logic [AW-1:0] DMA_A,
   input  logic [DW-1:0] DMA_DI,
   input  logic          DMA_WEn,
   input  logic [3:0]    DMA_BEn,
   output logic [DW-1:0] DMA_DO,
   output logic          DMA_READYn,

   output logic          RAM_CEn,
   output logic [AW-1:0] RAM_A,
   output logic [DW-1:0] RAM_DI,
   output logic          RAM_WEn,
   output logic [3:0]    RAM_BEn,
   input  logic [DW-1:0] RAM_DO,
   input  logic          RAM_READYn
);

   arb_state_t    state_q, state_d;
   logic          last_dma_q, last_dma_d;    // 1: DMA was served most recently
   ram_req_t      req_q, req_d;              // latched request driving RAM_*
   logic          ram_cen_q, ram_cen_d;
   logic [DW-1:0] cpu_do_q, cpu_do_d;
   logic [DW-1:0] dma_do_q, dma_do_d;
   logic          cpu_readyn_q, cpu_readyn_d;
   logic          dma_readyn_q, dma_readyn_d;

   // Next-state logic: grant in IDLE, wait for RAM in GNT_x, pulse ready in ACK.
   always_comb begin
      // NOTE: every _d defaults to its _q so no branch can leave a value unassigned and infer a latch.
      state_d      = state_q;
      last_dma_d   = last_dma_q;
      req_d        = req_q;
      ram_cen_d    = ram_cen_q;
      cpu_do_d     = cpu_do_q;
      dma_do_d     = dma_do_q;
      cpu_readyn_d = cpu_readyn_q;
      dma_readyn_d = dma_readyn_q;

      if (CE) begin
         case (state_q)
            IDLE: begin
               // DMA wins when it requests alone, or when both request and the CPU went last.
               if (!DMA_CEn && (CPU_CEn || !last_dma_q)) begin
                  req_d      = '{a: DMA_A, di: DMA_DI, wen: DMA_WEn, ben: DMA_BEn};
                  ram_cen_d  = 1'b0;
                  last_dma_d = 1'b1;
                  state_d    = GNT_DMA;
               end else if (!CPU_CEn) begin
                  req_d      = '{a: CPU_A, di: CPU_DI, wen: CPU_WEn, ben: CPU_BEn};
                  ram_cen_d  = 1'b0;
                  last_dma_d = 1'b0;
                  state_d    = GNT_CPU;
               end
            end
            GNT_CPU: begin
               if (!RAM_READYn) begin
                  if (req_q.wen) begin
                     cpu_do_d = RAM_DO;
                  end
                  ram_cen_d    = 1'b1;
                  cpu_readyn_d = 1'b0;
                  state_d      = ACK;
               end
            end
            GNT_DMA: begin
               if (!RAM_READYn) begin
                  if (req_q.wen) begin
                     dma_do_d = RAM_DO;
                  end
                  ram_cen_d    = 1'b1;
                  dma_readyn_d = 1'b0;
                  state_d      = ACK;
               end
            end
            ACK: begin
               cpu_readyn_d = 1'b1;
               dma_readyn_d = 1'b1;
               state_d      = IDLE;
            end
            default: begin
               state_d = IDLE;
            end
         endcase
      end
   end

   // State and output registers; reset wins over CE so a stalled machine still resets.
   always_ff @(posedge CLK) begin
      // NOTE: non-blocking assignments make every flop sample the pre-edge value of every other flop.
      if (RES) begin
         state_q      <= IDLE;
         last_dma_q   <= 1'b1;
         req_q        <= '{a: '0, di: '0, wen: 1'b1, ben: 4'hF};
         ram_cen_q    <= 1'b1;
         cpu_do_q     <= '0;
         dma_do_q     <= '0;
         cpu_readyn_q <= 1'b1;
         dma_readyn_q <= 1'b1;
      end else begin
         state_q      <= state_d;
         last_dma_q   <= last_dma_d;
         req_q        <= req_d;
         ram_cen_q    <= ram_cen_d;
         cpu_do_q     <= cpu_do_d;
         dma_do_q     <= dma_do_d;
         cpu_readyn_q <= cpu_readyn_d;
         dma_readyn_q <= dma_readyn_d;
      end
   end

   assign RAM_CEn    = ram_cen_q;
   assign RAM_A      = req_q.a;
   assign RAM_DI     = req_q.di;
   assign RAM_WEn    = req_q.wen;
   assign RAM_BEn    = req_q.ben;
   assign CPU_DO     = cpu_do_q;
   assign CPU_READYn = cpu_readyn_q;
   assign DMA_DO     = dma_do_q;
   assign DMA_READYn = dma_readyn_q;

endmodule
